axi_lite_clint: RTL and testbench

AXI_LITE_CLINT -- requirements
Module: axi_lite_clint

---
 rtl/holy_clint_pkg.sv | 65 ++++++
 rtl/axi_lite_slave_if.sv | 153 +++++++++++++++
 rtl/axi_lite_clint.sv | 180 ++++++++++++++++++
 tb/tb_axi_lite_clint.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/holy_clint_pkg.sv
// ============================================================================
// Module      : holy_clint_pkg
// Description : Shared register map, AXI response codes, FSM state types and
//               address-decode / byte-strobe helpers for the CLINT slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package holy_clint_pkg;

    localparam logic [31:0] c_OFF_MSIP        = 32'h0000_0000;
    localparam logic [31:0] c_OFF_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] c_OFF_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] c_OFF_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] c_OFF_MTIME_HI    = 32'h0000_BFFC;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        REG_NONE     = 3'd0,
        REG_MSIP     = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_MTIME_LO = 3'd4,
        REG_MTIME_HI = 3'd5
    } reg_sel_t;

    // Byte lane [1:0] of the offset is don't-care; everything else must match exactly.
    function automatic reg_sel_t decode_offset(input logic [31:0] offset);
        reg_sel_t sel;
        case (offset & 32'hFFFF_FFFC)
            c_OFF_MSIP:        sel = REG_MSIP;
            c_OFF_MTIMECMP_LO: sel = REG_CMP_LO;
            c_OFF_MTIMECMP_HI: sel = REG_CMP_HI;
            c_OFF_MTIME_LO:    sel = REG_MTIME_LO;
            c_OFF_MTIME_HI:    sel = REG_MTIME_HI;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_slave_if.sv
// ============================================================================
// Module      : axi_lite_slave_if
// Description : AXI-Lite slave handshake engine; turns the five AXI channels
//               into a single-cycle write strobe and a single-cycle read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_slave_if
    import holy_clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_strb,
    input  logic        i_wr_err,
    output logic        o_rd_en,
    output logic [31:0] o_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_err
);

    wr_state_t   r_wr_state;
    logic        r_aw_held;
    logic        r_w_held;
    logic [31:0] r_aw_addr;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    rd_state_t   r_rd_state;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_aw_hs;
    logic        w_w_hs;

    assign s_axi_awready = (r_wr_state == W_IDLE) && !r_aw_held;
    assign s_axi_wready  = (r_wr_state == W_IDLE) && !r_w_held;
    assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_w_hs        = s_axi_wvalid && s_axi_wready;

    // A channel arriving this cycle is used directly so the write lands on its handshake edge.
    assign o_wr_en   = (r_wr_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign o_wr_addr = r_aw_held ? r_aw_addr : s_axi_awaddr;
    assign o_wr_data = r_w_held  ? r_w_data  : s_axi_wdata;
    assign o_wr_strb = r_w_held  ? r_w_strb  : s_axi_wstrb;

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (o_wr_en) begin
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= i_wr_err ? c_RESP_SLVERR : c_RESP_OKAY;
                        r_wr_state <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_addr <= s_axi_awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_w_data <= s_axi_wdata;
                            r_w_strb <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign s_axi_arready = (r_rd_state == R_IDLE);
    assign o_rd_en       = s_axi_arvalid && s_axi_arready;
    assign o_rd_addr     = s_axi_araddr;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= c_RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (o_rd_en) begin
                        r_rvalid   <= 1'b1;
                        r_rdata    <= i_rd_err ? 32'd0 : i_rd_data;
                        r_rresp    <= i_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_lite_clint.sv
// ============================================================================
// Module      : axi_lite_clint
// Description : AXI-Lite core-local interruptor: 64-bit mtime, mtimecmp and
//               msip, driving timer_irq and soft_irq. Define CLINT_PRESCALER_EN
//               to divide the mtime tick by PRESCALE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_clint
    import holy_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic        timer_irq,
    output logic        soft_irq
);

    logic        w_wr_en;
    logic [31:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_wr_err;
    logic        w_rd_en;
    logic [31:0] w_rd_addr;
    logic [31:0] w_rd_data;
    logic        w_rd_err;
    reg_sel_t    w_wr_sel;
    reg_sel_t    w_rd_sel;
    logic        w_tick;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_timer_irq;
    logic        r_soft_irq;

    axi_lite_slave_if u_axi_if (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .o_wr_en       (w_wr_en),
        .o_wr_addr     (w_wr_addr),
        .o_wr_data     (w_wr_data),
        .o_wr_strb     (w_wr_strb),
        .i_wr_err      (w_wr_err),
        .o_rd_en       (w_rd_en),
        .o_rd_addr     (w_rd_addr),
        .i_rd_data     (w_rd_data),
        .i_rd_err      (w_rd_err)
    );

    assign w_wr_sel = decode_offset(w_wr_addr - BASE_ADDR);
    assign w_rd_sel = decode_offset(w_rd_addr - BASE_ADDR);
    assign w_wr_err = (w_wr_sel == REG_NONE);
    assign w_rd_err = (w_rd_sel == REG_NONE);

    // Read mux samples registers before this cycle's write, so a colliding read sees old data.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_en) begin
            case (w_rd_sel)
                REG_MSIP:     w_rd_data = {31'd0, r_msip};
                REG_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
                REG_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
                REG_MTIME_LO: w_rd_data = r_mtime[31:0];
                REG_MTIME_HI: w_rd_data = r_mtime[63:32];
                default:      w_rd_data = '0;
            endcase
        end
    end

`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] c_PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_presc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (r_presc_cnt == c_PRESC_LAST) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
        end
    end

    assign w_tick = (r_presc_cnt == c_PRESC_LAST);
`else
    logic [31:0] w_unused_prescale;

    assign w_unused_prescale = 32'(PRESCALE);
    assign w_tick            = 1'b1;
`endif

    // A software write to either mtime word replaces that cycle's increment entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (w_wr_en && (w_wr_sel == REG_MTIME_LO)) begin
            r_mtime[31:0] <= merge_strb(r_mtime[31:0], w_wr_data, w_wr_strb);
        end else if (w_wr_en && (w_wr_sel == REG_MTIME_HI)) begin
            r_mtime[63:32] <= merge_strb(r_mtime[63:32], w_wr_data, w_wr_strb);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
        end else if (w_wr_en) begin
            case (w_wr_sel)
                REG_MSIP: begin
                    if (w_wr_strb[0]) begin
                        r_msip <= w_wr_data[0];
                    end
                end
                REG_CMP_LO: r_mtimecmp[31:0]  <= merge_strb(r_mtimecmp[31:0], w_wr_data, w_wr_strb);
                REG_CMP_HI: r_mtimecmp[63:32] <= merge_strb(r_mtimecmp[63:32], w_wr_data, w_wr_strb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer_irq <= 1'b0;
            r_soft_irq  <= 1'b0;
        end else begin
            r_timer_irq <= (r_mtime >= r_mtimecmp);
            r_soft_irq  <= r_msip;
        end
    end

    assign timer_irq = r_timer_irq;
    assign soft_irq  = r_soft_irq;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_clint.sv
// ============================================================================
// Module      : tb_axi_lite_clint
// Description : Self-checking bench for axi_lite_clint (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_lite_clint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic        timer_irq;
    logic        soft_irq;

    always #5 clk = ~clk;

    axi_lite_clint dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .timer_irq     (timer_irq),
        .soft_irq      (soft_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mtime is pure arithmetic: last loaded value plus edges elapsed since loading.
    logic [63:0] m_cyc, m_base, m_base_cyc, m_cmp, m_mt;
    logic        m_msip, m_exp_timer, m_exp_soft;
    logic        m_aw_got, m_w_got, m_bpend, m_rpend;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_base = 0; m_base_cyc = 0; m_cmp = '1; m_msip = 0;
            m_exp_timer = 0; m_exp_soft = 0; m_aw_got = 0; m_w_got = 0;
            m_bpend = 0; m_rpend = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
        end else begin
            m_mt = m_base + (m_cyc - m_base_cyc);
            m_exp_timer = (m_mt >= m_cmp);
            m_exp_soft  = m_msip;
            m_cyc = m_cyc + 1;
            if (m_rpend && s_axi_rready) m_rpend = 0;
            if (s_axi_arvalid && s_axi_arready) begin
                m_rpend = 1; m_rresp = 2'b00;
                case (s_axi_araddr & 32'hFFFF_FFFC)
                    32'h0000_0000: m_rdata = {31'd0, m_msip};
                    32'h0000_4000: m_rdata = m_cmp[31:0];
                    32'h0000_4004: m_rdata = m_cmp[63:32];
                    32'h0000_BFF8: m_rdata = m_mt[31:0];
                    32'h0000_BFFC: m_rdata = m_mt[63:32];
                    default: begin m_rdata = 0; m_rresp = 2'b10; end
                endcase
            end
            if (m_bpend && s_axi_bready) m_bpend = 0;
            if (s_axi_awvalid && s_axi_awready) begin m_aw_got = 1; m_aw_addr = s_axi_awaddr; end
            if (s_axi_wvalid && s_axi_wready) begin m_w_got = 1; m_w_data = s_axi_wdata; m_w_strb = s_axi_wstrb; end
            if (m_aw_got && m_w_got) begin
                m_aw_got = 0; m_w_got = 0; m_bpend = 1; m_bresp = 2'b00;
                case (m_aw_addr & 32'hFFFF_FFFC)
                    32'h0000_0000: if (m_w_strb[0]) m_msip = m_w_data[0];
                    32'h0000_4000: m_cmp[31:0]  = bytes_merge(m_cmp[31:0], m_w_data, m_w_strb);
                    32'h0000_4004: m_cmp[63:32] = bytes_merge(m_cmp[63:32], m_w_data, m_w_strb);
                    32'h0000_BFF8: begin m_base = {m_mt[63:32], bytes_merge(m_mt[31:0], m_w_data, m_w_strb)}; m_base_cyc = m_cyc; end
                    32'h0000_BFFC: begin m_base = {bytes_merge(m_mt[63:32], m_w_data, m_w_strb), m_mt[31:0]}; m_base_cyc = m_cyc; end
                    default: m_bresp = 2'b10;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("timer_irq", timer_irq, m_exp_timer);
            check("soft_irq", soft_irq, m_exp_soft);
            check("rvalid", s_axi_rvalid, m_rpend);
            if (m_rpend) begin
                check("rdata", s_axi_rdata, m_rdata);
                check("rresp", s_axi_rresp, m_rresp);
            end
            check("bvalid", s_axi_bvalid, m_bpend);
            if (m_bpend) check("bresp", s_axi_bresp, m_bresp);
        end
    end

    // ---------------- drivers ----------------
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int k;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            if (s_axi_arready) break;
        end
        #1 s_axi_arvalid = 1'b0;
        check("ar_handshake", k < 20, 1);
        @(negedge clk);
        check("rd_latency", s_axi_rvalid, 1);
        d = s_axi_rdata; r = s_axi_rresp;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done;
        int c, k;
        aw_done = 0; w_done = 0; c = 0;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(aw_done && w_done) && c < 40) begin
            s_axi_awvalid = !aw_done && (c >= aw_dly);
            s_axi_wvalid  = !w_done && (c >= w_dly);
            @(posedge clk);
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1;
            #1 c++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("wr_handshake", aw_done && w_done, 1);
        for (k = 0; k < b_dly; k++) begin
            @(negedge clk);
            check("bvalid_hold", s_axi_bvalid, 1);
        end
        s_axi_bready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            if (s_axi_bvalid) break;
        end
        resp = s_axi_bresp;
        #1 s_axi_bready = 1'b0;
        check("b_handshake", k < 20, 1);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] d0, d1, rd_old;
    logic [1:0]  rr, br, br2;
    logic [63:0] w_edge;
    int          k;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_timer_irq", timer_irq, 0);
        check("rst_soft_irq", soft_irq, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);
        rst = 1'b0;

        // mtime free-runs one per cycle; handshakes 10 edges apart
        axi_read(32'h0000_BFF8, d0, rr);
        repeat (8) @(posedge clk);
        axi_read(32'h0000_BFF8, d1, rr);
        check("mtime_delta", d1 - d0, 10);
        check("mtime_rresp", rr, 2'b00);
        check("idle_timer_irq", timer_irq, 0);
        axi_read(32'h0000_4004, d0, rr);
        check("cmp_hi_reset", d0, 32'hFFFF_FFFF);

        // timer compare: rises exactly 101 edges after mtime was loaded with 0
        axi_write(32'h0000_BFFC, 32'd0, 4'hF, 0, 0, 0, br);
        axi_write(32'h0000_BFF8, 32'd0, 4'hF, 0, 0, 0, br);
        w_edge = m_base_cyc;
        axi_write(32'h0000_4004, 32'd0, 4'hF, 0, 0, 0, br);
        axi_write(32'h0000_4000, 32'd100, 4'hF, 0, 0, 0, br);
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (timer_irq) break;
        end
        check("timer_irq_rise", k < 300, 1);
        check("timer_irq_latency", m_cyc - w_edge, 101);
        axi_write(32'h0000_4004, 32'd1, 4'hF, 0, 0, 0, br);
        repeat (2) @(negedge clk);
        check("timer_irq_fall", timer_irq, 0);

        // msip byte-strobe behaviour
        axi_write(32'h0000_0000, 32'd1, 4'h1, 0, 0, 0, br);
        repeat (2) @(negedge clk);
        check("soft_irq_set", soft_irq, 1);
        axi_read(32'h0000_0000, d0, rr);
        check("msip_read", d0, 1);
        axi_write(32'h0000_0000, 32'd0, 4'h1, 0, 0, 0, br);
        repeat (2) @(negedge clk);
        check("soft_irq_clr", soft_irq, 0);
        axi_write(32'h0000_0000, 32'd1, 4'h0, 0, 0, 0, br);
        axi_write(32'h0000_0000, 32'hFFFF_FFFF, 4'hE, 0, 0, 0, br);
        repeat (2) @(negedge clk);
        check("soft_irq_nostrb", soft_irq, 0);

        // channel ordering with a stalled response
        axi_write(32'h0000_4000, 32'h1111_2222, 4'hF, 3, 0, 5, br);
        check("w_first_bresp", br, 2'b00);
        axi_write(32'h0000_4000, 32'hA5A5_5A5A, 4'h6, 0, 3, 5, br);
        check("aw_first_bresp", br, 2'b00);
        axi_read(32'h0000_4000, d0, rr);
        check("strb_merge", d0, 32'h11A5_5A22);

        // simultaneous read/write of the same register returns the old value
        fork
            axi_write(32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br2);
            axi_read(32'h0000_4000, rd_old, rr);
        join
        check("rw_collision_old", rd_old, 32'h11A5_5A22);
        axi_read(32'h0000_4000, d0, rr);
        check("rw_collision_new", d0, 32'hDEAD_BEEF);

        // low-word wrap carries into the high word
        axi_write(32'h0000_BFFC, 32'd0, 4'hF, 0, 0, 0, br);
        axi_write(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
        axi_read(32'h0000_BFFC, d0, rr);
        check("wrap_hi", d0, 1);
        axi_read(32'h0000_BFF8, d1, rr);
        check("wrap_lo_small", d1 < 32, 1);

        // unmapped accesses
        axi_read(32'h0000_1234, d0, rr);
        check("unmapped_rresp", rr, 2'b10);
        check("unmapped_rdata", d0, 0);
        axi_write(32'h0000_1234, 32'h5555_5555, 4'hF, 0, 0, 0, br);
        check("unmapped_bresp", br, 2'b10);

        // reset while a read response is pending
        s_axi_rready = 1'b0;
        @(posedge clk); #1;
        s_axi_araddr = 32'h0000_BFF8; s_axi_arvalid = 1'b1;
        @(posedge clk); #1 s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_pending", s_axi_rvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_rvalid", s_axi_rvalid, 0);
        check("rst_clears_rdata", s_axi_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_axi_rready = 1'b1;
        axi_read(32'h0000_4004, d0, rr);
        check("post_rst_cmp_hi", d0, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
